mem_access: RTL and testbench

- MEM pipeline stage: the consumer end of the EX→MEM interface.
- Takes the EX outputs (ALU result, store data, destination register, memory control) and performs load/store on the data-memory bus with a req/ack handshake.
- Produces the registered MEM/WB bundle and stalls EX while a memory access is outstanding.

---
 rtl/psrv32_pkg.sv | 58 +++++
 rtl/mem_align.sv | 52 +++++
 rtl/mem_access.sv | 166 ++++++++++++++++
 tb/tb_mem_access.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psrv32_pkg.sv
// Shared MEM-stage definitions: funct3 access codes, stage state, and the
// EX/MEM and MEM/WB bundle types used by mem_access and mem_align.
package psrv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  write_reg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [2:0]  funct3;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwrite;
    } mem_wb_t;

    // What must survive from acceptance until the bus acknowledges.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
        logic        regwrite;
        logic        is_load;
        logic [2:0]  funct3;
    } mem_pend_t;

    function automatic acc_size_t f3_size(input logic [2:0] f3);
        if (f3[1:0] == F3_B[1:0])      return SZ_BYTE;
        else if (f3[1:0] == F3_H[1:0]) return SZ_HALF;
        else                           return SZ_WORD;
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load/store lane logic: store byte enables and lane-replicated
// write data, misalignment detection, and load byte/half extraction with extension.
module mem_align
    import psrv32_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        st_be      = 4'b1111;
        st_wdata   = st_data;
        misaligned = 1'b0;
        case (f3_size(st_funct3))
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be      = 4'b0011 << st_offset;
                st_wdata   = {2{st_data[15:0]}};
                misaligned = st_offset[0];
            end
            default: misaligned = (st_offset != 2'b00);
        endcase
    end

    always_comb begin
        byte_shift = ld_rdata >> {ld_offset, 3'b000};
        half_shift = ld_rdata >> {ld_offset[1], 4'b0000};
        case (f3_size(ld_funct3))
            SZ_BYTE: ld_data = f3_unsigned(ld_funct3) ? {24'b0, byte_shift[7:0]}
                                                      : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SZ_HALF: ld_data = f3_unsigned(ld_funct3) ? {16'b0, half_shift[15:0]}
                                                      : {{16{half_shift[15]}}, half_shift[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: accepts the EX bundle, runs loads/stores over a req/ack
// data bus and emits the registered MEM/WB bundle. Build option MEM_TIMEOUT_EN adds bus_err_o.
module mem_access
    import psrv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data2_i,
    input  logic [4:0]  write_reg_i,
    input  logic        regwrite_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_regwrite_o,
    output logic        misaligned_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        bus_err_o
`endif
);

    mem_state_t  state_q, state_d;
    ex_mem_t     ex;
    mem_pend_t   pend_q;
    mem_wb_t     wb_q;
    logic        misal_q;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        st_misaligned;
    logic [31:0] ld_data;
    logic        accept, is_mem, pass_hit, start_mem, misal_hit, ack_hit, timeout_hit;

    assign ex = '{alu_result: alu_result_i, store_data: read_data2_i,
                  write_reg: write_reg_i, regwrite: regwrite_i,
                  memread: memread_i, memwrite: memwrite_i, funct3: funct3_i};

    mem_align u_align (
        .st_funct3  (ex.funct3),
        .st_offset  (ex.alu_result[1:0]),
        .st_data    (ex.store_data),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .misaligned (st_misaligned),
        .ld_funct3  (pend_q.funct3),
        .ld_offset  (pend_q.alu_result[1:0]),
        .ld_rdata   (dmem_rdata_i),
        .ld_data    (ld_data)
    );

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    assign bus_err_o = bus_err_q;
`else
    wire unused_cfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
`endif

    always_comb begin
        accept      = ex_valid_i && (state_q == S_IDLE);
        is_mem      = ex.memread || ex.memwrite;
        pass_hit    = accept && !is_mem;
        start_mem   = accept && is_mem && !st_misaligned;
        misal_hit   = accept && is_mem && st_misaligned;
        ack_hit     = (state_q == S_WAIT) && dmem_ack_i;
        timeout_hit = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timeout_hit = (state_q == S_WAIT) && !dmem_ack_i
                      && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_mem) state_d = S_WAIT;
            S_WAIT:  if (ack_hit || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // NOTE: every datapath register is reset so outputs are defined from the first cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            pend_q       <= '0;
            wb_q         <= '0;
            misal_q      <= 1'b0;
        end else begin
            wb_q.valid <= 1'b0;
            misal_q    <= 1'b0;
            if (pass_hit) begin
                wb_q <= '{valid: 1'b1, data: ex.alu_result, rd: ex.write_reg, regwrite: ex.regwrite};
            end
            if (misal_hit) begin
                wb_q    <= '{valid: 1'b1, data: ex.alu_result, rd: ex.write_reg, regwrite: 1'b0};
                misal_q <= 1'b1;
            end
            if (start_mem) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= ex.memwrite;
                dmem_addr_o  <= {ex.alu_result[31:2], 2'b00};
                dmem_be_o    <= st_be;
                dmem_wdata_o <= st_wdata;
                pend_q       <= '{alu_result: ex.alu_result, write_reg: ex.write_reg,
                                  regwrite: ex.regwrite, is_load: !ex.memwrite,
                                  funct3: ex.funct3};
            end
            if (ack_hit) begin
                dmem_req_o <= 1'b0;
                wb_q <= '{valid: 1'b1,
                          data: pend_q.is_load ? ld_data : pend_q.alu_result,
                          rd: pend_q.write_reg,
                          regwrite: pend_q.regwrite && pend_q.is_load};
            end
            if (timeout_hit) begin
                dmem_req_o <= 1'b0;
                wb_q <= '{valid: 1'b1, data: pend_q.alu_result, rd: pend_q.write_reg, regwrite: 1'b0};
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Counter only advances while a request waits unanswered; restarts on each new access.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (start_mem)                                cnt_q <= '0;
            else if ((state_q == S_WAIT) && !dmem_ack_i) cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    assign ex_ready_o    = (state_q == S_IDLE);
    assign wb_valid_o    = wb_q.valid;
    assign wb_data_o     = wb_q.data;
    assign wb_rd_o       = wb_q.rd;
    assign wb_regwrite_o = wb_q.regwrite;
    assign misaligned_o  = misal_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written
// multi-cycle sequences (back-to-back, stray ack, reset mid-access) and random ops vs a model.
module tb_mem_access;
    import psrv32_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] read_data2_i = '0;
    logic [4:0]  write_reg_i = '0;
    logic        regwrite_i = 1'b0;
    logic        memread_i = 1'b0;
    logic        memwrite_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o, wb_regwrite_o, misaligned_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err_o;
`endif

    always #5 clk_i = ~clk_i;

    mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_result_i(alu_result_i), .read_data2_i(read_data2_i),
        .write_reg_i(write_reg_i), .regwrite_i(regwrite_i),
        .memread_i(memread_i), .memwrite_i(memwrite_i), .funct3_i(funct3_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .wb_regwrite_o(wb_regwrite_o), .misaligned_o(misaligned_o)
`ifdef MEM_TIMEOUT_EN
        , .bus_err_o(bus_err_o)
`endif
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          delay;
        logic        misal, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, wbd;
        logic        wbrw;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] alu, sd, input logic [4:0] rd,
                                input logic rw, mr, mw, input logic [2:0] f3,
                                input logic [31:0] rdata, input int delay,
                                input logic misal, we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata, wbd,
                                input logic wbrw);
        vec_t v;
        v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
        v.f3 = f3; v.rdata = rdata; v.delay = delay; v.misal = misal; v.we = we;
        v.addr = addr; v.be = be; v.wdata = wdata; v.wbd = wbd; v.wbrw = wbrw;
        return v;
    endfunction

    // Expected behaviour from the access rules: size, offset, lane replication, extension.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int          size, off;
        logic [31:0] val;
        size    = v.f3[1] ? 4 : (v.f3[0] ? 2 : 1);
        off     = int'(v.alu[1:0]);
        r.misal = (v.mr || v.mw) && ((off % size) != 0);
        r.we    = v.mw;
        r.addr  = v.alu & ~32'h3;
        r.be    = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = v.sd[8*(i % size) +: 8];
        val = '0;
        for (int i = 0; i < size; i++)
            if (off + i < 4) val[8*i +: 8] = v.rdata[8*(off+i) +: 8];
        if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        r.wbd  = v.mw ? 32'h0 : (v.mr ? val : v.alu);
        r.wbrw = (v.mr || v.mw) ? (v.rw && !v.mw && !r.misal) : v.rw;
        return r;
    endfunction

    // Entered and left at posedge+1 with the stage idle.
    task automatic apply(input vec_t v, input string name);
        check({name, ":ready"}, ex_ready_o, 1);
        ex_valid_i = 1'b1; alu_result_i = v.alu; read_data2_i = v.sd; write_reg_i = v.rd;
        regwrite_i = v.rw; memread_i = v.mr; memwrite_i = v.mw; funct3_i = v.f3;
        dmem_rdata_i = $urandom;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
        if (!(v.mr || v.mw) || v.misal) begin
            check({name, ":wb_valid"}, wb_valid_o, 1);
            check({name, ":misaligned"}, misaligned_o, v.misal);
            check({name, ":no_req"}, dmem_req_o, 0);
            check({name, ":wb_regwrite"}, wb_regwrite_o, v.wbrw);
            check({name, ":ready_after"}, ex_ready_o, 1);
            if (!v.misal) begin
                check({name, ":wb_data"}, wb_data_o, v.wbd);
                check({name, ":wb_rd"}, wb_rd_o, v.rd);
            end
        end else begin
            check({name, ":req"}, dmem_req_o, 1);
            check({name, ":we"}, dmem_we_o, v.we);
            check({name, ":addr"}, dmem_addr_o, v.addr);
            check({name, ":busy"}, ex_ready_o, 0);
            check({name, ":no_wb_yet"}, wb_valid_o, 0);
            if (v.we) begin
                check({name, ":be"}, dmem_be_o, v.be);
                check({name, ":wdata"}, dmem_wdata_o, v.wdata);
            end
            for (int i = 0; i < v.delay; i++) begin
                @(posedge clk_i); #1;
                check({name, ":req_held"}, dmem_req_o, 1);
                check({name, ":addr_held"}, dmem_addr_o, v.addr);
                check({name, ":busy_wait"}, ex_ready_o, 0);
            end
            dmem_ack_i = 1'b1; dmem_rdata_i = v.rdata;
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
            check({name, ":req_drop"}, dmem_req_o, 0);
            check({name, ":wb_valid"}, wb_valid_o, 1);
            check({name, ":wb_rd"}, wb_rd_o, v.rd);
            check({name, ":wb_regwrite"}, wb_regwrite_o, v.wbrw);
            check({name, ":misaligned"}, misaligned_o, 0);
            check({name, ":ready_after"}, ex_ready_o, 1);
            if (!v.we) check({name, ":wb_data"}, wb_data_o, v.wbd);
        end
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        //            alu           sd            rd  rw mr mw f3     rdata         dly  mis we addr          be       wdata         wbd           wbrw
        tbl[0]  = mk(32'h0000_1234, 32'h0,        5,  1, 0, 0, F3_B,  32'h0,        0,   0, 0, 32'h0,        4'h0, 32'h0,        32'h0000_1234, 1);
        tbl[1]  = mk(32'h0000_1003, 32'hAB,       3,  0, 0, 1, F3_B,  32'h0,        3,   0, 1, 32'h0000_1000, 4'h8, 32'hABAB_ABAB, 32'h0,        0);
        tbl[2]  = mk(32'h0000_2001, 32'h0,        7,  1, 1, 0, F3_B,  32'h0000_80FF, 1,  0, 0, 32'h0000_2000, 4'h0, 32'h0,        32'hFFFF_FF80, 1);
        tbl[3]  = mk(32'h0000_2001, 32'h0,        8,  1, 1, 0, F3_BU, 32'h0000_80FF, 0,  0, 0, 32'h0000_2000, 4'h0, 32'h0,        32'h0000_0080, 1);
        tbl[4]  = mk(32'h0000_3002, 32'h0,        9,  1, 1, 0, F3_W,  32'h0,        0,   1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0);
        tbl[5]  = mk(32'h0000_4002, 32'h1234_ABCD, 2, 0, 0, 1, F3_H,  32'h0,        2,   0, 1, 32'h0000_4000, 4'hC, 32'hABCD_ABCD, 32'h0,        0);
        tbl[6]  = mk(32'h0000_5000, 32'hDEAD_BEEF, 2, 1, 0, 1, F3_W,  32'h0,        0,   0, 1, 32'h0000_5000, 4'hF, 32'hDEAD_BEEF, 32'h0,        0);
        tbl[7]  = mk(32'h0000_6002, 32'h0,        10, 1, 1, 0, F3_H,  32'h8001_7FFF, 1,  0, 0, 32'h0000_6000, 4'h0, 32'h0,        32'hFFFF_8001, 1);
        tbl[8]  = mk(32'h0000_6002, 32'h0,        11, 1, 1, 0, F3_HU, 32'h8001_7FFF, 0,  0, 0, 32'h0000_6000, 4'h0, 32'h0,        32'h0000_8001, 1);
        tbl[9]  = mk(32'h0000_7004, 32'h0,        12, 1, 1, 0, F3_W,  32'h1234_5678, 2,  0, 0, 32'h0000_7004, 4'h0, 32'h0,        32'h1234_5678, 1);
        tbl[10] = mk(32'h0000_4001, 32'h55,       13, 1, 0, 1, F3_H,  32'h0,        0,   1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0);
        tbl[11] = mk(32'h0000_8000, 32'hCAFE_F00D, 14, 1, 1, 1, F3_W, 32'h0,        1,   0, 1, 32'h0000_8000, 4'hF, 32'hCAFE_F00D, 32'h0,        0);
        tbl[12] = mk(32'h0000_2003, 32'h0,        15, 1, 1, 0, F3_B,  32'h7F00_0000, 0,  0, 0, 32'h0000_2000, 4'h0, 32'h0,        32'h0000_007F, 1);
        tbl[13] = mk(32'hFFFF_FFFC, 32'h0,        31, 0, 0, 0, F3_W,  32'h0,        0,   0, 0, 32'h0,        4'h0, 32'h0,        32'hFFFF_FFFC, 0);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst:ready", ex_ready_o, 1);
        check("rst:req", dmem_req_o, 0);
        check("rst:we", dmem_we_o, 0);
        check("rst:addr", dmem_addr_o, 0);
        check("rst:be", dmem_be_o, 0);
        check("rst:wdata", dmem_wdata_o, 0);
        check("rst:wb_valid", wb_valid_o, 0);
        check("rst:wb_data", wb_data_o, 0);
        check("rst:wb_rd", wb_rd_o, 0);
        check("rst:wb_regwrite", wb_regwrite_o, 0);
        check("rst:misaligned", misaligned_o, 0);
        reset_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back non-memory bundles, then the pulse must end
        ex_valid_i = 1'b1; alu_result_i = 32'h11; write_reg_i = 5'd1; regwrite_i = 1'b1;
        memread_i = 1'b0; memwrite_i = 1'b0;
        @(posedge clk_i); #1;
        alu_result_i = 32'h22; write_reg_i = 5'd2;
        check("b2b:wb0_valid", wb_valid_o, 1);
        check("b2b:wb0_data", wb_data_o, 32'h11);
        check("b2b:ready", ex_ready_o, 1);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        check("b2b:wb1_valid", wb_valid_o, 1);
        check("b2b:wb1_data", wb_data_o, 32'h22);
        check("b2b:wb1_rd", wb_rd_o, 2);
        @(posedge clk_i); #1;
        check("b2b:pulse_end", wb_valid_o, 0);

        // Stray ack while idle has no effect
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        check("idle_ack:wb_valid", wb_valid_o, 0);
        check("idle_ack:req", dmem_req_o, 0);
        check("idle_ack:ready", ex_ready_o, 1);

        // Reset in the middle of WAIT drops the request immediately
        ex_valid_i = 1'b1; alu_result_i = 32'h0000_9000; write_reg_i = 5'd4; regwrite_i = 1'b1;
        memread_i = 1'b1; memwrite_i = 1'b0; funct3_i = F3_W;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; memread_i = 1'b0;
        check("rstw:req_before", dmem_req_o, 1);
        #2 reset_ni = 1'b0;
        #1;
        check("rstw:req_async", dmem_req_o, 0);
        check("rstw:ready_async", ex_ready_o, 1);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        check("rstw:no_wb", wb_valid_o, 0);
        check("rstw:ready", ex_ready_o, 1);
        @(posedge clk_i); #1;
        check("rstw:no_wb_late", wb_valid_o, 0);
        check("rstw:req_off", dmem_req_o, 0);

`ifdef MEM_TIMEOUT_EN
        // Unanswered request aborts after four WAIT cycles
        ex_valid_i = 1'b1; alu_result_i = 32'h0000_A000; write_reg_i = 5'd6; regwrite_i = 1'b1;
        memread_i = 1'b1; funct3_i = F3_W;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; memread_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo:req_wait", dmem_req_o, 1);
            check("tmo:no_err", bus_err_o, 0);
            @(posedge clk_i); #1;
        end
        check("tmo:req_drop", dmem_req_o, 0);
        check("tmo:bus_err", bus_err_o, 1);
        check("tmo:wb_valid", wb_valid_o, 1);
        check("tmo:wb_regwrite", wb_regwrite_o, 0);
        check("tmo:ready", ex_ready_o, 1);
        @(posedge clk_i); #1;
        check("tmo:err_pulse_end", bus_err_o, 0);
`endif

        // Random operations against the model
        for (int i = 0; i < 200; i++) begin
            rv.alu   = $urandom;
            rv.sd    = $urandom;
            rv.rd    = 5'($urandom_range(0, 31));
            rv.rw    = 1'($urandom_range(0, 1));
            rv.mr    = 1'($urandom_range(0, 1));
            rv.mw    = 1'($urandom_range(0, 1));
            rv.f3    = 3'($urandom_range(0, 7));
            rv.rdata = $urandom;
            rv.delay = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) rv.alu[1:0] = 2'b00;
            rv = model(rv);
            apply(rv, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
